ser_par: RTL
============

# ser_par

Serial-to-parallel deserializer that sits directly downstream of the 8-bit parallel-to-serial shifter. It consumes the shifter's MSB-first serial stream, framed by a one-cycle `sync` pulse marking the first data bit. It reassembles each frame into a parallel word and presents it with a one-cycle `valid` pulse. It also flags frames broken by an early `sync` and keeps a wrapping count of good frames.

## Interface
- `WIDTH`, default 8: bits per frame; the minimum is 2.
- `MSB_FIRST`, default 1: 1 means the first serial bit is `d_out[WIDTH-1]`; 0 means the first bit is `d_out[0]`.
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high. Clears all state immediately.
- `sync`, input, 1: high for the one cycle in which `d_in` carries the first bit of a frame.
- `d_in`, input, 1: serial data; it is sampled on every rising edge while a frame is being received.
- `d_out`, output, `WIDTH`: the last completed word. It is held until the next frame completes.
- `valid`, output, 1: a one-cycle pulse when `d_out` is updated.
- `busy`, output, 1: high while a frame is partially received.
- `frame_err`, output, 1: a one-cycle pulse when a frame is aborted by an early `sync`.
- `frame_cnt`, output, 8: the number of good frames, wrapping 255 -> 0.

## Operation
- The block has two states, IDLE and SHIFT. It also has an internal shift register `sr[WIDTH-1:0]` and a bit counter `cnt` of width clog2(`WIDTH`).
- IDLE:
  - With `sync`=0, `d_in` is ignored and no state changes.
  - With `sync`=1, the block captures `d_in` as bit 0 of the frame, sets `cnt`=1 and goes to SHIFT.
- SHIFT, with `sync`=0: the block captures `d_in` and increments `cnt`. When the captured bit is bit `WIDTH-1` (`cnt`=`WIDTH-1` before the edge), the frame completes at that edge:
  - `d_out` is loaded with the completed word and `valid` is set to 1.
  - `frame_cnt` is incremented.
  - The state returns to IDLE.
- SHIFT, with `sync`=1: this is an early `sync`, and it applies even on the cycle that would have carried the final bit.
  - The partial frame is discarded, `frame_err` is set to 1, and `d_out` and `frame_cnt` are unchanged.
  - The current `d_in` is captured as bit 0 of a new frame; `cnt`=1 and the state stays in SHIFT.
- Bit ordering:
  - With `MSB_FIRST`=1, the register shifts left and the new bit enters at the LSB. A frame 1,0,1,0,0,1,0,1 gives 8'hA5.
  - With `MSB_FIRST`=0, the register shifts right and the new bit enters at the MSB, so the first bit ends up at `d_out[0]`.
- `busy` is high exactly when the state is SHIFT.
- `d_in` and `sync` are synchronous to `clk`; the block has no metastability handling.

## Timing
- Reset values, asynchronous:
  - `d_out`=0, `valid`=0, `busy`=0, `frame_err`=0, `frame_cnt`=0.
  - State IDLE, `sr`=0, `cnt`=0.
- A reset asserted mid-frame aborts the frame silently: no `valid` and no `frame_err`.
- In the first cycle after `rst` deasserts, a `sync` is honoured.
- Latency: call the cycle with `sync`=1 cycle 0.
  - The bits are sampled at the ends of cycles 0 through `WIDTH-1`.
  - `valid` is high and `d_out` is new during cycle `WIDTH`, which is 8 cycles after `sync` when `WIDTH`=8.
- Back-to-back frames: a `sync` in cycle `WIDTH`, the same cycle `valid` is high, is legal and starts the next frame with no error. Sustained throughput is one word per `WIDTH` cycles.
- Alignment with the upstream shifter: its `strobe` edge is followed by the MSB appearing on its output during the next cycle. The frame source asserts `sync` in that cycle.
- `valid` and `frame_err` are registered and never both high in the same cycle.
- `frame_cnt` updates on the same edge that raises `valid`.

## Test plan
- Reset, then `sync` plus the serial bits of 8'hA5 MSB-first -> `valid` is high exactly in cycle 8, `d_out`=8'hA5, `frame_cnt`=1, and `busy` is high in cycles 1-7.
- Frames 8'h3C then 8'hC3 with no gap, the second `sync` in cycle 8 -> `valid` is seen in cycles 8 and 16, with `d_out` 8'h3C then 8'hC3, `frame_err` never high, and `frame_cnt`=2.
- Start 8'hFF, then issue a `sync` in cycle 3 followed by the bits of 8'h81 -> `frame_err` is high in cycle 4, the single `valid` is in cycle 11 with `d_out`=8'h81, and `frame_cnt` rises by 1 only.
- `rst` asserted mid-cycle during cycle 5 of a frame -> all outputs are 0 immediately, no `valid` or `frame_err` follows, and a later clean frame 8'h5A is received correctly.
- `d_in` toggling for 50 cycles with `sync`=0 -> `valid`, `busy` and `frame_err` stay 0, and `d_out` is unchanged.
- 256 consecutive good frames -> `frame_cnt` wraps to 0 on the 256th `valid`. Repeat with `MSB_FIRST`=0 and first bits 1,0,1,0,0,0,0,0 -> `d_out`=8'h05.

Source files
------------

// File: rtl/ser_par_if.sv
// Serial link bundle between the frame source and the ser_par deserializer.
// The source drives sync/d_in; the deserializer returns the word, status pulses and frame count.
// WIDTH must match the WIDTH of the ser_par instance bound to it.
interface ser_par_if #(
  parameter int WIDTH = 8
);
  logic             sync;
  logic             d_in;
  logic [WIDTH-1:0] d_out;
  logic             valid;
  logic             busy;
  logic             frame_err;
  logic [7:0]       frame_cnt;

  modport master (
    output sync, d_in,
    input  d_out, valid, busy, frame_err, frame_cnt
  );

  modport slave (
    input  sync, d_in,
    output d_out, valid, busy, frame_err, frame_cnt
  );
endinterface

// File: rtl/ser_par.sv
// Serial-to-parallel deserializer: rebuilds WIDTH-bit words from a sync-framed serial stream.
// Latency: valid pulses WIDTH cycles after the sync cycle; one word per WIDTH cycles sustained.
// No backpressure: every bit is sampled as it arrives; an early sync drops the partial frame.
module ser_par #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic      clk,
  input logic      rst,
  ser_par_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       fcnt_q, fcnt_d;

  // Register contents after taking d_in: continuing the current frame or starting a new one.
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fresh;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sr_q[WIDTH-2:0], bus.d_in};
      assign fresh   = {{(WIDTH-1){1'b0}}, bus.d_in};
    end else begin : g_lsb
      assign shifted = {bus.d_in, sr_q[WIDTH-1:1]};
      assign fresh   = {bus.d_in, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // Next-state and next-output logic; status pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.sync) begin
          sr_d    = fresh;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sync) begin
          // Early sync wins even on the final-bit cycle: drop the partial word, restart.
          sr_d  = fresh;
          cnt_d = CW'(1);
          err_d = 1'b1;
        end else begin
          sr_d = shifted;
          if (cnt_q == CW'(WIDTH - 1)) begin
            dout_d  = shifted;
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + 8'd1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame without raising a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.d_out     = dout_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = err_q;
  assign bus.frame_cnt = fcnt_q;
  assign bus.busy      = (state_q == SHIFT);

endmodule
